screen_out_stage: RTL and testbench
===================================

Name: screen_out_stage

Overview:
- Parametrised successor of the screen output/enable stage.
- Sits between the end of the display-unit chain and the VGA/LCD connectors.
- Composites NUM_LAYERS colour sources by fixed priority over a background colour, and applies per-channel brightness levels plus a frame-locked fade-in/fade-out.
- Blanks outside the active area and delays hsync/vsync/de to match a configurable upstream colour latency plus its own pipeline.

Parameters:
- NUM_LAYERS, 4, number of drawing layers; index 0 has highest priority; range 1..8.
- CB, 4, colour bits per channel.
- RGB_LAT, 0, cycles by which upstream colour lags pxl_en/hsync/vsync; range 0..7.
- FADE_FRAMES, 2, frames per fade step; range 1..15.

Ports:
- clk_25  in  1  pixel clock; the only clock.
- resetN  in  1  asynchronous, active-low reset.
- pxl_en  in  1  active-area enable, aligned with the syncs.
- hsync_in  in  1  horizontal sync, active-low.
- vsync_in  in  1  vertical sync, active-low.
- layer_draw  in  NUM_LAYERS  per-layer "pixel drawn" flags.
- layer_rgb  in  NUM_LAYERS*3*CB  packed {r,g,b} per layer; layer k at bits [k*3*CB +: 3*CB].
- bg_rgb  in  3*CB  background {r,g,b}.
- red_level  in  CB  red brightness.
- green_level  in  CB  green brightness.
- blue_level  in  CB  blue brightness.
- fade_req  in  1  single-cycle fade request.
- fade_dir  in  1  sampled with fade_req: 1 = fade in, 0 = fade out.
- red  out  CB  output red.
- green  out  CB  output green.
- blue  out  CB  output blue.
- hsync  out  1  delayed horizontal sync.
- vsync  out  1  delayed vertical sync.
- de  out  1  delayed data enable.
- fade_busy  out  1  high while a fade is in progress.
- fade_level  out  CB  current fade level.

Behaviour:
- Reset (resetN=0, async): red/green/blue=0, de=0, hsync=1, vsync=1, fade_busy=0, fade_level=all-ones (fully visible), state IDLE, all delay stages cleared (sync stages to 1).
- Enable alignment: pxl_en is delayed RGB_LAT cycles to en_a. en_a is the enable aligned with the layer/bg colour inputs.
- Stage 1 (registered):
  - sel = lowest index k with layer_draw[k]=1, else bg_rgb.
  - Colour is forced to 0 when en_a=0.
- Stage 2 (registered):
  - Per channel, eff = min(channel_level, fade_level).
  - out = (c*(eff+1)) >> CB, using a 2*CB-bit product.
  - eff=all-ones passes colour unchanged; eff=0 gives c>>CB, i.e. 0 for any c.
- Latency:
  - Colour: 2 cycles from colour input.
  - hsync/vsync/de: delayed exactly RGB_LAT+2 cycles from hsync_in/vsync_in/pxl_en.
  - Result: outputs mutually aligned; de=0 implies rgb=0.
- Frame tick: vsync_in falling edge detected with a 1-cycle registered compare. A divider counts ticks 0..FADE_FRAMES-1; a step occurs when the count wraps.
- Fade FSM states: IDLE, FADE_IN, FADE_OUT.
  - Any state, fade_req=1 with fade_dir=1: go to FADE_IN. fade_level is kept, not restarted. Divider is cleared.
  - Any state, fade_req=1 with fade_dir=0: go to FADE_OUT, with the same rules.
  - FADE_IN, each step: fade_level+1. On reaching all-ones: go to IDLE.
  - FADE_OUT, each step: fade_level-1. On reaching 0: go to IDLE; level is held at 0 (screen dark).
  - Saturating: no wrap in either direction.
  - fade_busy = (state != IDLE).
  - fade_req while busy in the same direction: divider restarts; level is not changed.
- Simultaneous fade_req and step tick: fade_req wins; no step that cycle.
- Fade request when already at target (e.g. fade-in at all-ones): enters FADE_IN, returns to IDLE on the next step with level unchanged.
- Reset mid-fade: immediate return to IDLE with fade_level=all-ones.
- Levels are sampled combinationally at stage 2. No level shadowing: a mid-line level change takes effect on the next pixel.

Decomposition:
- Package screen_pkg:
  - typedef fade_state_t {IDLE, FADE_IN, FADE_OUT}.
  - localparam PIPE_LAT=2.
  - typedef rgb_t as a packed struct of CB-bit r/g/b, with a CB default of 4.
- Sub-module sync_delay_line:
  - Parameters DEPTH and RESET_VAL.
  - A 1-bit shift register; DEPTH=0 is a pass-through.
  - Instantiated for hsync, vsync and pxl_en (pxl_en twice: RGB_LAT, then PIPE_LAT).

Test Plan:
- Priority with RGB_LAT=0, levels=F, fade idle. Layers 1 and 3 drawn; layer1=0x3A5, layer3=0xFFF; pxl_en=1. Expect rgb=0x3A5 two cycles later and de=1 aligned with it.
- Blanking: pxl_en=0 with layer0 drawn 0xFFF. Expect rgb=0x000 and de=0.
- Latency with RGB_LAT=3:
  - Single-cycle low pulse on hsync_in at cycle t; expect hsync low at exactly t+5.
  - Colour applied at t+3 with pxl_en high at t; expect colour visible at t+5.
- Brightness: colour 0xF84, red_level=7, green_level=F, blue_level=0. Expect red=(15*8)>>4=7, green=8, blue=0.
- Fade: FADE_FRAMES=2, fade_req with fade_dir=0.
  - fade_level decrements every 2 vsync falling edges: F,E,…,0 after 30 frames, then fade_busy=0.
  - Then fade_req with fade_dir=1 on the same cycle as a step tick: no step that cycle; level rises after 2 more frames.
- Reset mid-fade: resetN low while fade_level=6 in FADE_OUT. Expect immediately fade_level=F, fade_busy=0, hsync=vsync=1, rgb=0.

Source files
------------

// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - shared types and constants for the screen output stage
package screen_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FADE_IN  = 2'd1,
      FADE_OUT = 2'd2
   } fade_state_t;

   localparam int PIPE_LAT   = 2;
   localparam int CB_DEFAULT = 4;

   typedef struct packed {
      logic [CB_DEFAULT-1:0] r;
      logic [CB_DEFAULT-1:0] g;
      logic [CB_DEFAULT-1:0] b;
   } rgb_t;

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - 1-bit shift register delay, DEPTH=0 is a wire
module sync_delay_line #(
   parameter int   DEPTH     = 1,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_25,
   input  logic resetN,
   input  logic d,
   output logic q
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_clk_rst;
         assign unused_clk_rst = &{1'b0, clk_25, resetN};
         assign q = d;
      end else begin : g_shift
         logic [DEPTH-1:0] sr;
         always_ff @(posedge clk_25 or negedge resetN) begin
            if (!resetN) begin
               sr <= {DEPTH{RESET_VAL}};
            end else begin
               sr[0] <= d;
               for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
         end
         assign q = sr[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/screen_out_stage.sv
// rtl/screen_out_stage.sv - layer compositing, brightness/fade scaling, sync alignment
module screen_out_stage
   import screen_pkg::*;
#(
   parameter int NUM_LAYERS  = 4,
   parameter int CB          = 4,
   parameter int RGB_LAT     = 0,
   parameter int FADE_FRAMES = 2
) (
   input  logic                       clk_25,
   input  logic                       resetN,
   input  logic                       pxl_en,
   input  logic                       hsync_in,
   input  logic                       vsync_in,
   input  logic [NUM_LAYERS-1:0]      layer_draw,
   input  logic [NUM_LAYERS*3*CB-1:0] layer_rgb,
   input  logic [3*CB-1:0]            bg_rgb,
   input  logic [CB-1:0]              red_level,
   input  logic [CB-1:0]              green_level,
   input  logic [CB-1:0]              blue_level,
   input  logic                       fade_req,
   input  logic                       fade_dir,
   output logic [CB-1:0]              red,
   output logic [CB-1:0]              green,
   output logic [CB-1:0]              blue,
   output logic                       hsync,
   output logic                       vsync,
   output logic                       de,
   output logic                       fade_busy,
   output logic [CB-1:0]              fade_level
);

   localparam int              CW       = 3 * CB;
   localparam logic [CB-1:0]   LVL_MAX  = '1;
   localparam logic [CB-1:0]   LVL_ONE  = 1;
   localparam logic [2*CB-1:0] ONE2     = 1;
   localparam logic [3:0]      DIV_LAST = 4'(FADE_FRAMES - 1);

   logic          en_a;
   logic [CW-1:0] sel_rgb;
   logic [CW-1:0] col1;

   sync_delay_line #(.DEPTH(RGB_LAT), .RESET_VAL(1'b0)) u_en_a (
      .clk_25(clk_25), .resetN(resetN), .d(pxl_en), .q(en_a));
   sync_delay_line #(.DEPTH(PIPE_LAT), .RESET_VAL(1'b0)) u_de (
      .clk_25(clk_25), .resetN(resetN), .d(en_a), .q(de));
   sync_delay_line #(.DEPTH(RGB_LAT + PIPE_LAT), .RESET_VAL(1'b1)) u_hs (
      .clk_25(clk_25), .resetN(resetN), .d(hsync_in), .q(hsync));
   sync_delay_line #(.DEPTH(RGB_LAT + PIPE_LAT), .RESET_VAL(1'b1)) u_vs (
      .clk_25(clk_25), .resetN(resetN), .d(vsync_in), .q(vsync));

   // Walk from the top so the lowest drawn index is the last to overwrite.
   always_comb begin
      sel_rgb = bg_rgb;
      for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
         if (layer_draw[k]) sel_rgb = layer_rgb[k*CW +: CW];
      end
   end

   always_ff @(posedge clk_25 or negedge resetN) begin
      if (!resetN) col1 <= '0;
      else         col1 <= en_a ? sel_rgb : '0;
   end

   function automatic logic [CB-1:0] scale(input logic [CB-1:0] c,
                                           input logic [CB-1:0] lvl,
                                           input logic [CB-1:0] fl);
      logic [CB-1:0]   eff;
      logic [2*CB-1:0] prod;
      eff  = (lvl < fl) ? lvl : fl;
      prod = {{CB{1'b0}}, c} * ({{CB{1'b0}}, eff} + ONE2);
      return prod[2*CB-1:CB];
   endfunction

   always_ff @(posedge clk_25 or negedge resetN) begin
      if (!resetN) begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end else begin
         red   <= scale(col1[3*CB-1:2*CB], red_level,   fade_level);
         green <= scale(col1[2*CB-1:CB],   green_level, fade_level);
         blue  <= scale(col1[CB-1:0],      blue_level,  fade_level);
      end
   end

   fade_state_t   state_q, state_n;
   logic [CB-1:0] level_q, level_n;
   logic [3:0]    div_q, div_n;
   logic          vs_q;
   logic          frame_tick;
   logic          step;

   assign frame_tick = vs_q & ~vsync_in;

   always_ff @(posedge clk_25 or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;
         level_q <= LVL_MAX;
         div_q   <= '0;
         vs_q    <= 1'b1;
      end else begin
         state_q <= state_n;
         level_q <= level_n;
         div_q   <= div_n;
         vs_q    <= vsync_in;
      end
   end

   // A request always wins over a frame step and restarts the divider.
   always_comb begin
      state_n = state_q;
      level_n = level_q;
      div_n   = div_q;
      step    = 1'b0;
      if (fade_req) begin
         state_n = fade_dir ? FADE_IN : FADE_OUT;
         div_n   = '0;
      end else if (frame_tick) begin
         if (div_q == DIV_LAST) begin
            div_n = '0;
            step  = 1'b1;
         end else begin
            div_n = div_q + 4'd1;
         end
         if (step) begin
            case (state_q)
               FADE_IN: begin
                  if (level_q >= LVL_MAX - LVL_ONE) state_n = IDLE;
                  if (level_q != LVL_MAX) level_n = level_q + LVL_ONE;
               end
               FADE_OUT: begin
                  if (level_q <= LVL_ONE) state_n = IDLE;
                  if (level_q != '0) level_n = level_q - LVL_ONE;
               end
               default: state_n = IDLE;
            endcase
         end
      end
   end

   assign fade_busy  = (state_q != IDLE);
   assign fade_level = level_q;

endmodule

// File: tb/tb_screen_out_stage.sv
// tb/tb_screen_out_stage.sv - scoreboard bench for screen_out_stage
module tb_screen_out_stage;

   logic        clk_25 = 1'b0;
   logic        resetN;
   logic        pxl_en, hsync_in, vsync_in, fade_req, fade_dir;
   logic [3:0]  layer_draw;
   logic [47:0] layer_rgb;
   logic [11:0] bg_rgb;
   logic [3:0]  red_level, green_level, blue_level;

   logic [3:0] r0, g0, b0, lvl0, r3, g3, b3, lvl3;
   logic       hs0, vs0, de0, busy0, hs3, vs3, de3, busy3;

   always #20 clk_25 = ~clk_25;

   screen_out_stage #(.NUM_LAYERS(4), .CB(4), .RGB_LAT(0), .FADE_FRAMES(2)) dut0 (
      .clk_25(clk_25), .resetN(resetN), .pxl_en(pxl_en), .hsync_in(hsync_in),
      .vsync_in(vsync_in), .layer_draw(layer_draw), .layer_rgb(layer_rgb),
      .bg_rgb(bg_rgb), .red_level(red_level), .green_level(green_level),
      .blue_level(blue_level), .fade_req(fade_req), .fade_dir(fade_dir),
      .red(r0), .green(g0), .blue(b0), .hsync(hs0), .vsync(vs0), .de(de0),
      .fade_busy(busy0), .fade_level(lvl0));

   screen_out_stage #(.NUM_LAYERS(4), .CB(4), .RGB_LAT(3), .FADE_FRAMES(2)) dut3 (
      .clk_25(clk_25), .resetN(resetN), .pxl_en(pxl_en), .hsync_in(hsync_in),
      .vsync_in(vsync_in), .layer_draw(layer_draw), .layer_rgb(layer_rgb),
      .bg_rgb(bg_rgb), .red_level(red_level), .green_level(green_level),
      .blue_level(blue_level), .fade_req(fade_req), .fade_dir(fade_dir),
      .red(r3), .green(g3), .blue(b3), .hsync(hs3), .vsync(vs3), .de(de3),
      .fade_busy(busy3), .fade_level(lvl3));

   int cyc = 0;
   always @(posedge clk_25) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int          when;
      int          dut;
      logic [11:0] rgb;
      logic        de;
      logic        hs;
      int          tag;
   } exp_t;

   exp_t sbq[$];

   task automatic push(input int when, input int dut, input logic [11:0] rgb,
                       input logic de, input logic hs, input int tag);
      exp_t e;
      e.when = when; e.dut = dut; e.rgb = rgb; e.de = de; e.hs = hs; e.tag = tag;
      sbq.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t        e;
      logic [13:0] act;
      forever begin
         @(negedge clk_25);
         while (sbq.size() > 0 && sbq[0].when <= cyc) begin
            e   = sbq.pop_front();
            act = (e.dut == 0) ? {r0, g0, b0, de0, hs0} : {r3, g3, b3, de3, hs3};
            n_tests++;
            if (e.when != cyc || act !== {e.rgb, e.de, e.hs}) begin
               n_fail++;
               $display("FAIL pix_%0d dut%0d cyc %0d: got rgb=%h de=%b hs=%b, expected rgb=%h de=%b hs=%b at cyc %0d",
                        e.tag, (e.dut == 0) ? 0 : 3, cyc, act[13:2], act[1], act[0],
                        e.rgb, e.de, e.hs, e.when);
            end
         end
      end
   end

   task automatic idle_inputs();
      pxl_en = 1'b0; hsync_in = 1'b1; layer_draw = 4'b0000;
      layer_rgb = '0; bg_rgb = '0; fade_req = 1'b0;
   endtask

   task automatic frame();
      @(negedge clk_25) vsync_in = 1'b0;
      @(negedge clk_25) vsync_in = 1'b1;
      @(negedge clk_25);
   endtask

   task automatic request(input logic dir);
      @(negedge clk_25) begin fade_req = 1'b1; fade_dir = dir; end
      @(negedge clk_25) fade_req = 1'b0;
   endtask

   initial begin : stim
      idle_inputs();
      vsync_in = 1'b1; fade_dir = 1'b0;
      red_level = 4'hF; green_level = 4'hF; blue_level = 4'hF;
      resetN = 1'b0;
      repeat (3) @(negedge clk_25);
      chk("reset_dut0", {r0, g0, b0, de0, hs0, vs0, busy0, lvl0}, {12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF});
      chk("reset_dut3", {r3, g3, b3, de3, hs3, vs3, busy3, lvl3}, {12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF});
      resetN = 1'b1;
      repeat (4) @(negedge clk_25);

      // Layer priority, background and blanking on the zero-latency instance
      layer_draw = 4'b1010; layer_rgb = {12'hFFF, 12'h000, 12'h3A5, 12'h000}; pxl_en = 1'b1;
      push(cyc + 2, 0, 12'h3A5, 1'b1, 1'b1, 1);
      @(negedge clk_25);
      idle_inputs();
      push(cyc + 2, 0, 12'h000, 1'b0, 1'b1, 2);
      @(negedge clk_25);
      bg_rgb = 12'h123; pxl_en = 1'b1;
      push(cyc + 2, 0, 12'h123, 1'b1, 1'b1, 3);
      @(negedge clk_25);
      layer_draw = 4'b1111; layer_rgb = {12'hCCC, 12'hBBB, 12'hAAA, 12'h9E1}; pxl_en = 1'b1;
      push(cyc + 2, 0, 12'h9E1, 1'b1, 1'b1, 4);
      @(negedge clk_25);
      idle_inputs();
      layer_draw = 4'b0001; layer_rgb = {36'h0, 12'hFFF};
      push(cyc + 2, 0, 12'h000, 1'b0, 1'b1, 5);
      @(negedge clk_25);
      idle_inputs();
      repeat (8) @(negedge clk_25);

      // RGB_LAT=3: sync pulse and enable at t, colour at t+3, all visible at t+5
      begin
         int t;
         t = cyc;
         hsync_in = 1'b0; pxl_en = 1'b1;
         push(t + 4, 1, 12'h000, 1'b0, 1'b1, 10);
         push(t + 5, 1, 12'h5C7, 1'b1, 1'b0, 11);
         push(t + 6, 1, 12'h000, 1'b0, 1'b1, 12);
         @(negedge clk_25) idle_inputs();
         repeat (2) @(negedge clk_25);
         layer_draw = 4'b0001; layer_rgb = {36'h0, 12'h5C7};
         @(negedge clk_25) idle_inputs();
      end
      repeat (10) @(negedge clk_25);

      // Per-channel brightness
      red_level = 4'h7; green_level = 4'hF; blue_level = 4'h0;
      @(negedge clk_25);
      layer_draw = 4'b0001; layer_rgb = {36'h0, 12'hF84}; pxl_en = 1'b1;
      push(cyc + 2, 0, 12'h780, 1'b1, 1'b1, 20);
      @(negedge clk_25) idle_inputs();
      repeat (3) @(negedge clk_25);
      red_level = 4'h8; green_level = 4'h8; blue_level = 4'h8;
      @(negedge clk_25);
      layer_draw = 4'b0001; layer_rgb = {36'h0, 12'hF84}; pxl_en = 1'b1;
      push(cyc + 2, 0, 12'h842, 1'b1, 1'b1, 21);
      @(negedge clk_25) idle_inputs();
      repeat (3) @(negedge clk_25);
      red_level = 4'hF; green_level = 4'hF; blue_level = 4'hF;
      repeat (4) @(negedge clk_25);

      // Fade out: one step per two frames, F down to 0
      request(1'b0);
      chk("fade_out_start", {busy0, lvl0}, {1'b1, 4'hF});
      for (int k = 1; k <= 15; k++) begin
         frame();
         frame();
         chk($sformatf("fade_out_step%0d", k), {busy0, lvl0}, {(k < 15), 4'(15 - k)});
      end

      // Fade-in request coincident with a divider wrap: request wins
      frame();
      @(negedge clk_25) begin vsync_in = 1'b0; fade_req = 1'b1; fade_dir = 1'b1; end
      @(negedge clk_25) begin vsync_in = 1'b1; fade_req = 1'b0; end
      @(negedge clk_25);
      chk("fade_in_req_on_tick", {busy0, lvl0}, {1'b1, 4'h0});
      frame();
      chk("fade_in_one_frame", {busy0, lvl0}, {1'b1, 4'h0});
      frame();
      chk("fade_in_two_frames", {busy0, lvl0}, {1'b1, 4'h1});

      // Same-direction request restarts the divider without touching the level
      frame();
      request(1'b1);
      frame();
      chk("restart_hold", {busy0, lvl0}, {1'b1, 4'h1});
      frame();
      chk("restart_step", {busy0, lvl0}, {1'b1, 4'h2});
      repeat (8) frame();
      chk("fade_in_to_6", {busy0, lvl0}, {1'b1, 4'h6});
      request(1'b0);
      chk("fade_out_at_6", {busy0, lvl0}, {1'b1, 4'h6});

      // Reset mid-fade with active pixels and a low hsync in flight
      layer_draw = 4'b0001; layer_rgb = {36'h0, 12'hFFF}; pxl_en = 1'b1; hsync_in = 1'b0;
      repeat (6) @(negedge clk_25);
      chk("pre_reset_out", {r0, g0, b0, de0, hs0}, {12'h666, 1'b1, 1'b0});
      resetN = 1'b0;
      #1;
      chk("mid_fade_reset", {r0, g0, b0, de0, hs0, vs0, busy0, lvl0},
          {12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF});
      idle_inputs();
      @(negedge clk_25) resetN = 1'b1;
      repeat (10) @(negedge clk_25);

      if (sbq.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_drain: got %0d pending entries, expected 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
